mem_port_arbiter: RTL and testbench

- Sequences the single shared memory port between the instruction-fetch stage (IF) and the data-access stage (MEM) of the 5-stage pipeline.
- Drives the IorD address-select signal and the memory request handshake.
- Generates the stall signals that freeze PC/IFID (`stall_if`) and the pipeline up to EX/MEM (`stall_mem`) while an access is outstanding.
- Includes a watchdog that traps a memory that never answers.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with stall
// generation and a watchdog that traps a memory that never answers.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              IorD,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StIfWait,
        StDmWait,
        StResp,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              iord_q, iord_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_done_q, dm_done_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_pend_d  = flush_pend_q;
        ram_req_d     = ram_req_q;
        ram_we_d      = ram_we_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        iord_d        = iord_q;
        if_instr_d    = if_instr_q;
        dm_rdata_d    = dm_rdata_q;
        if_valid_d    = 1'b0;
        dm_done_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                // Data wins a tie: it belongs to the older instruction.
                if (mem_rd || mem_wr) begin
                    state_d     = StDmWait;
                    ram_req_d   = 1'b1;
                    ram_addr_d  = dm_addr;
                    ram_wdata_d = dm_wdata;
                    ram_we_d    = mem_wr;
                    iord_d      = 1'b1;
                    cnt_d       = '0;
                end else if (if_req) begin
                    state_d     = StIfWait;
                    ram_req_d   = 1'b1;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = dm_wdata;
                    ram_we_d    = 1'b0;
                    iord_d      = 1'b0;
                    cnt_d       = '0;
                end
            end
            StIfWait, StDmWait: begin
                if (state_q == StIfWait && flush) begin
                    flush_pend_d = 1'b1;
                end
                if (ram_ready) begin
                    state_d   = StResp;
                    ram_req_d = 1'b0;
                    if (state_q == StIfWait) begin
                        if (!(flush_pend_q || flush)) begin
                            if_instr_d = ram_rdata;
                            if_valid_d = 1'b1;
                        end
                    end else begin
                        dm_done_d = 1'b1;
                        if (!ram_we_q) begin
                            dm_rdata_d = ram_rdata;
                        end
                    end
                end else if (cnt_q == CntMax - CntOne) begin
                    state_d       = StErr;
                    ram_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    cnt_d         = CntMax;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StResp: begin
                // Never issue from here so a finished data access is not repeated.
                state_d      = StIdle;
                flush_pend_d = 1'b0;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            flush_pend_q  <= 1'b0;
            ram_req_q     <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            iord_q        <= 1'b0;
            if_instr_q    <= '0;
            dm_rdata_q    <= '0;
            if_valid_q    <= 1'b0;
            dm_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_pend_q  <= flush_pend_d;
            ram_req_q     <= ram_req_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            iord_q        <= iord_d;
            if_instr_q    <= if_instr_d;
            dm_rdata_q    <= dm_rdata_d;
            if_valid_q    <= if_valid_d;
            dm_done_q     <= dm_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        stall_mem = 1'b0;
        stall_if  = 1'b0;
        if (state_q == StErr) begin
            stall_mem = 1'b1;
            stall_if  = 1'b1;
        end else begin
            stall_mem = (mem_rd | mem_wr) & ~dm_done_q;
            stall_if  = stall_mem | (if_req & ~if_valid_q);
        end
    end

    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign dm_rdata    = dm_rdata_q;
    assign dm_done     = dm_done_q;
    assign IorD        = iord_q;
    assign ram_req     = ram_req_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, store, flush, reset and watchdog.
module tb_mem_port_arbiter;

    logic        Clock;
    logic        Reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        stall_if;
    logic        stall_mem;
    logic        IorD;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        timeout_err;

    int checks;
    int failures;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .flush      (flush),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .if_instr   (if_instr),
        .if_valid   (if_valid),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .IorD       (IorD),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .timeout_err(timeout_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        Reset_n   = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        flush     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        ram_rdata = '0;
        ram_ready = 1'b0;

        #12;
        chk("rst_ram_req", ram_req, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_dm_done", dm_done, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_iord", IorD, 0);
        chk("rst_stall_if", stall_if, 0);
        chk("rst_stall_mem", stall_mem, 0);
        chk("rst_if_instr", if_instr, 0);
        #10 Reset_n = 1'b1;

        // Fetch 0x40, ready in first wait cycle
        tick(); if_req = 1'b1; if_addr = 32'h40; #1;
        chk("f_c0_stall_if", stall_if, 1);
        chk("f_c0_ram_req", ram_req, 0);
        tick(); ram_ready = 1'b1; ram_rdata = 32'h8C010004; #1;
        chk("f_c1_ram_req", ram_req, 1);
        chk("f_c1_ram_addr", ram_addr, 32'h40);
        chk("f_c1_iord", IorD, 0);
        chk("f_c1_stall_if", stall_if, 1);
        tick(); ram_ready = 1'b0; #1;
        chk("f_c2_if_valid", if_valid, 1);
        chk("f_c2_if_instr", if_instr, 32'h8C010004);
        chk("f_c2_ram_req", ram_req, 0);
        chk("f_c2_stall_if", stall_if, 0);
        if_req = 1'b0;
        tick(); #1;
        chk("f_c3_if_valid", if_valid, 0);
        chk("f_c3_if_instr_hold", if_instr, 32'h8C010004);

        // Simultaneous fetch 0x44 and load 0x100: data first
        tick(); if_req = 1'b1; if_addr = 32'h44; mem_rd = 1'b1; dm_addr = 32'h100; #1;
        chk("s_c0_stall_mem", stall_mem, 1);
        chk("s_c0_stall_if", stall_if, 1);
        tick(); ram_ready = 1'b1; ram_rdata = 32'h12345678; #1;
        chk("s_c1_iord", IorD, 1);
        chk("s_c1_ram_addr", ram_addr, 32'h100);
        chk("s_c1_ram_we", ram_we, 0);
        tick(); ram_ready = 1'b0; #1;
        chk("s_c2_dm_done", dm_done, 1);
        chk("s_c2_dm_rdata", dm_rdata, 32'h12345678);
        chk("s_c2_stall_mem", stall_mem, 0);
        chk("s_c2_stall_if", stall_if, 1);
        chk("s_c2_if_instr", if_instr, 32'h8C010004);
        mem_rd = 1'b0;
        tick(); #1;
        chk("s_c3_ram_req", ram_req, 0);
        chk("s_c3_dm_done", dm_done, 0);
        tick(); ram_ready = 1'b1; ram_rdata = 32'h00000020; #1;
        chk("s_c4_ram_req", ram_req, 1);
        chk("s_c4_iord", IorD, 0);
        chk("s_c4_ram_addr", ram_addr, 32'h44);
        tick(); ram_ready = 1'b0; #1;
        chk("s_c5_if_valid", if_valid, 1);
        chk("s_c5_if_instr", if_instr, 32'h20);
        if_req = 1'b0;
        tick();

        // Store 0x200 <- DEADBEEF, ready in second wait cycle
        tick(); mem_wr = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; #1;
        tick(); dm_wdata = 32'h0; #1;
        chk("w_c1_ram_we", ram_we, 1);
        chk("w_c1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("w_c1_ram_addr", ram_addr, 32'h200);
        chk("w_c1_iord", IorD, 1);
        tick(); ram_ready = 1'b1; ram_rdata = 32'hFFFFFFFF; #1;
        chk("w_c2_ram_we", ram_we, 1);
        chk("w_c2_ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("w_c2_ram_req", ram_req, 1);
        tick(); ram_ready = 1'b0; #1;
        chk("w_c3_dm_done", dm_done, 1);
        chk("w_c3_dm_rdata", dm_rdata, 32'h12345678);
        chk("w_c3_stall_mem", stall_mem, 0);
        chk("w_c3_ram_req", ram_req, 0);
        mem_wr = 1'b0;
        tick();

        // Flush during fetch 0x48
        tick(); if_req = 1'b1; if_addr = 32'h48; #1;
        tick(); #1;
        chk("fl_c1_ram_addr", ram_addr, 32'h48);
        tick(); flush = 1'b1; #1;
        tick(); flush = 1'b0; ram_ready = 1'b1; ram_rdata = 32'hBAD0BAD0; #1;
        tick(); ram_ready = 1'b0; #1;
        chk("fl_c4_if_valid", if_valid, 0);
        chk("fl_c4_if_instr", if_instr, 32'h20);
        chk("fl_c4_ram_req", ram_req, 0);
        if_req = 1'b0;
        tick(); #1;
        chk("fl_c5_if_valid", if_valid, 0);
        chk("fl_c5_ram_req", ram_req, 0);
        // Next fetch must deliver normally once flush_pend has cleared
        tick(); if_req = 1'b1; if_addr = 32'h4C; #1;
        tick(); ram_ready = 1'b1; ram_rdata = 32'h0000ABCD; #1;
        chk("fl2_ram_addr", ram_addr, 32'h4C);
        tick(); ram_ready = 1'b0; #1;
        chk("fl2_if_valid", if_valid, 1);
        chk("fl2_if_instr", if_instr, 32'h0000ABCD);
        if_req = 1'b0;
        tick();

        // Reset during DM_WAIT
        tick(); mem_rd = 1'b1; dm_addr = 32'h300; #1;
        tick(); #1;
        chk("r_c1_ram_req", ram_req, 1);
        #2 Reset_n = 1'b0; #1;
        chk("r_async_ram_req", ram_req, 0);
        chk("r_async_iord", IorD, 0);
        chk("r_async_dm_rdata", dm_rdata, 0);
        mem_rd = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h55555555;
        tick(); Reset_n = 1'b1; #1;
        chk("r_hold_dm_done", dm_done, 0);
        ram_ready = 1'b0;
        tick(); #1;
        chk("r_rel_ram_req", ram_req, 0);
        chk("r_rel_dm_done", dm_done, 0);
        tick(); mem_rd = 1'b1; dm_addr = 32'h304; #1;
        tick(); ram_ready = 1'b1; ram_rdata = 32'h0BADCAFE; #1;
        chk("r_new_ram_addr", ram_addr, 32'h304);
        tick(); ram_ready = 1'b0; #1;
        chk("r_new_dm_done", dm_done, 1);
        chk("r_new_dm_rdata", dm_rdata, 32'h0BADCAFE);
        mem_rd = 1'b0;
        tick();

        // Watchdog: fetch 0x50, memory never answers
        tick(); if_req = 1'b1; if_addr = 32'h50; #1;
        for (int i = 1; i <= 8; i++) begin
            tick(); #1;
            chk("t_wait_ram_req", ram_req, 1);
            chk("t_wait_timeout", timeout_err, 0);
        end
        tick(); if_req = 1'b0; ram_ready = 1'b1; #1;
        chk("t_err_timeout", timeout_err, 1);
        chk("t_err_ram_req", ram_req, 0);
        chk("t_err_stall_if", stall_if, 1);
        chk("t_err_stall_mem", stall_mem, 1);
        tick(); tick(); #1;
        chk("t_hold_timeout", timeout_err, 1);
        chk("t_hold_stall_mem", stall_mem, 1);
        chk("t_hold_if_valid", if_valid, 0);
        Reset_n = 1'b0; #1;
        chk("t_rst_timeout", timeout_err, 0);
        chk("t_rst_stall_if", stall_if, 0);
        chk("t_rst_stall_mem", stall_mem, 0);
        chk("t_rst_ram_req", ram_req, 0);
        ram_ready = 1'b0;
        tick(); Reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
